ibex_rf_wb_arbiter: RTL and testbench
=====================================

// Module: ibex_rf_wb_arbiter
// PURPOSE
// - Owns the single write port (waddr/wdata/we) of the ibex register file; two writers share it.
// - Writers: EX writeback (ALU/MD, single-cycle) and LSU load responses (in order, any latency).
// - Scoreboards load destinations plus one held EX write; drives the decode read-hazard stall.
// - Sits between the ID/EX writeback mux and ibex_register_file.
// PARAMETERS
// - MaxOutstanding  2   max in-flight loads (FIFO depth, >=1)
// - DataWidth      32   register data width
// PORTS
// - clk_i              in   1   clock
// - rst_ni             in   1   asynchronous active-low reset
// - ex_we_i            in   1   EX write request
// - ex_waddr_i         in   5   EX destination register
// - ex_wdata_i         in   DW  EX write data
// - ex_ready_o         out  1   EX write accepted this cycle
// - lsu_req_i          in   1   load issued; reserve destination
// - lsu_req_waddr_i    in   5   load destination register
// - lsu_req_ready_o    out  1   reservation accepted (FIFO not full)
// - lsu_rvalid_i       in   1   load response (cannot be back-pressured)
// - lsu_err_i          in   1   response is a bus error
// - lsu_rdata_i        in   DW  load data
// - raddr_a_i/raddr_b_i in 5   decode read addresses
// - ren_a_i/ren_b_i    in   1   read port in use
// - rf_waddr_o         out  5   to register file waddr_a_i
// - rf_wdata_o         out  DW  to register file wdata_a_i
// - rf_we_o            out  1   to register file we_a_i
// - stall_o            out  1   read hazard: hold decode
// - fwd_a_o/fwd_b_o    out  1   read port served from skid data
// - fwd_data_o         out  DW  skid buffer data
// - pending_cnt_o      out  $clog2(MaxOutstanding+1)  loads in flight
// BEHAVIOUR
// - Reset: FIFO and skid empty; rf_we_o=0, stall_o=0, fwd_*=0, pending_cnt_o=0; ex_ready_o=1, lsu_req_ready_o=1.
// - Load FIFO: push {waddr} on lsu_req_i&&lsu_req_ready_o; pop on lsu_rvalid_i; push+pop same cycle keeps count.
// - lsu_req_ready_o = !full; no same-cycle pass-through when full, even if lsu_rvalid_i pops.
// - lsu_rvalid_i with empty FIFO: protocol error, ignored (assertion).
// - Write priority: (1) LSU response, (2) held skid entry, (3) new EX write. One write per cycle, combinational, 0 latency.
// - LSU response writes popped addr with lsu_rdata_i unless lsu_err_i=1 or addr==0; entry popped regardless.
// - Skid states: EMPTY, HELD. EMPTY: accepted EX write goes straight to port, or into skid if LSU writes this cycle.
//   HELD: drains on first cycle without LSU write -> EMPTY; new EX write may not enter same cycle.
// - ex_ready_o = skid EMPTY && no valid FIFO entry with addr==ex_waddr_i (WAW) ; ex_waddr_i==0 always ready, never written.
// - Hazard: port p hazards if ren_p && raddr_p!=0 && (matches any valid FIFO entry || matches skid addr while HELD).
// - stall_o = OR of port hazards; evaluated on current-cycle state (response this cycle still stalls; clears next cycle).
// - Reset mid-operation discards FIFO and skid; no write emitted after rst_ni falls.
// CONFIGURATION
// - IBEX_RF_WB_FWD_EN defined: skid-addr matches do not stall; fwd_p_o=1, fwd_data_o=skid data. FIFO matches still stall.
// - Undefined: fwd_a_o=fwd_b_o=0, fwd_data_o=0; skid matches stall.
// TESTING
// - EX write x5=0xA5A5_0001, idle LSU -> same cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA5A5_0001.
// - Load to x7 reserved, read x7 -> stall_o=1 until cycle after rvalid (rdata 0x1234) writes x7=0x1234.
// - rvalid(x7) and EX write x9 same cycle -> x7 written, x9 held; next cycle x9 written; ex_ready_o=0 while HELD.
// - Reserve 2 loads -> lsu_req_ready_o=0, pending_cnt_o=2; response with lsu_err_i=1 -> no write, count 1.
// - EX write x7 while load x7 pending -> ex_ready_o=0 until the load response pops; load to x0 -> no stall, no write.
// - Held x9, read x9: macro off -> stall_o=1; macro on -> stall_o=0, fwd_a_o=1, fwd_data_o=held data.

Source files
------------

// File: rtl/ibex_rf_wb_arbiter_if.sv
// Writeback arbiter bus: EX/LSU write requests, load reservations, decode
// hazard queries and the register-file write port, grouped into one bundle.
// slave = arbiter side, master = pipeline side.
interface ibex_rf_wb_arbiter_if #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned DataWidth      = 32
);
  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  logic                 ex_we;
  logic [AddrW-1:0]     ex_waddr;
  logic [DataWidth-1:0] ex_wdata;
  logic                 ex_ready;

  logic                 lsu_req;
  logic [AddrW-1:0]     lsu_req_waddr;
  logic                 lsu_req_ready;
  logic                 lsu_rvalid;
  logic                 lsu_err;
  logic [DataWidth-1:0] lsu_rdata;

  logic [AddrW-1:0]     raddr_a;
  logic [AddrW-1:0]     raddr_b;
  logic                 ren_a;
  logic                 ren_b;

  logic [AddrW-1:0]     rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 rf_we;

  logic                 stall;
  logic                 fwd_a;
  logic                 fwd_b;
  logic [DataWidth-1:0] fwd_data;
  logic [CntW-1:0]      pending_cnt;

  modport slave (
    input  ex_we, ex_waddr, ex_wdata,
    input  lsu_req, lsu_req_waddr, lsu_rvalid, lsu_err, lsu_rdata,
    input  raddr_a, raddr_b, ren_a, ren_b,
    output ex_ready, lsu_req_ready,
    output rf_waddr, rf_wdata, rf_we,
    output stall, fwd_a, fwd_b, fwd_data, pending_cnt
  );

  modport master (
    output ex_we, ex_waddr, ex_wdata,
    output lsu_req, lsu_req_waddr, lsu_rvalid, lsu_err, lsu_rdata,
    output raddr_a, raddr_b, ren_a, ren_b,
    input  ex_ready, lsu_req_ready,
    input  rf_waddr, rf_wdata, rf_we,
    input  stall, fwd_a, fwd_b, fwd_data, pending_cnt
  );
endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-port arbiter for ibex.
// Shares the single RF write port between EX writeback and in-order LSU load
// responses. Load destinations are tracked in a small FIFO; an EX write that
// collides with a load response is parked in a one-entry skid buffer.
// Write priority: LSU response > held skid entry > new EX write.
// Optional feature macro IBEX_RF_WB_FWD_EN: decode reads that hit the skid
// entry are forwarded from it instead of stalling.
module ibex_rf_wb_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned DataWidth      = 32
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ibex_rf_wb_arbiter_if.slave  bus
);

  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    SKID_EMPTY,
    SKID_HELD
  } skid_state_e;

  logic [AddrW-1:0]          fifo_addr_q [MaxOutstanding];
  logic [MaxOutstanding-1:0] fifo_valid_q;
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]           count_q, count_d;

  skid_state_e               state_q, state_d;
  logic [AddrW-1:0]          skid_addr_q, skid_addr_d;
  logic [DataWidth-1:0]      skid_data_q, skid_data_d;

  logic                      empty, full, push, pop;
  logic [AddrW-1:0]          head_addr;
  logic                      lsu_we, ex_accept, ex_waw;
  logic                      fifo_hit_a, fifo_hit_b;
  logic                      skid_hit_a, skid_hit_b;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // FIFO status, load response decode and write-after-write / hazard matching
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CntW'(MaxOutstanding));
    push       = bus.lsu_req && !full;
    pop        = bus.lsu_rvalid && !empty;
    head_addr  = fifo_addr_q[rd_ptr_q];
    lsu_we     = pop && !bus.lsu_err && (head_addr != '0);
    ex_waw     = 1'b0;
    fifo_hit_a = 1'b0;
    fifo_hit_b = 1'b0;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (fifo_valid_q[i]) begin
        if (fifo_addr_q[i] == bus.ex_waddr) ex_waw     = 1'b1;
        if (fifo_addr_q[i] == bus.raddr_a)  fifo_hit_a = 1'b1;
        if (fifo_addr_q[i] == bus.raddr_b)  fifo_hit_b = 1'b1;
      end
    end
    fifo_hit_a = fifo_hit_a && bus.ren_a && (bus.raddr_a != '0);
    fifo_hit_b = fifo_hit_b && bus.ren_b && (bus.raddr_b != '0);
    skid_hit_a = (state_q == SKID_HELD) && bus.ren_a && (bus.raddr_a != '0) &&
                 (bus.raddr_a == skid_addr_q);
    skid_hit_b = (state_q == SKID_HELD) && bus.ren_b && (bus.raddr_b != '0) &&
                 (bus.raddr_b == skid_addr_q);
  end

  // Occupancy bookkeeping: push and pop in the same cycle leave the count unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Load-destination FIFO storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) fifo_addr_q[i] <= '0;
      fifo_valid_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q]  <= bus.lsu_req_waddr;
        fifo_valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        fifo_valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q               <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  // Skid state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SKID_EMPTY;
      skid_addr_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Skid next state and the prioritised write-port mux
  always_comb begin
    state_d       = state_q;
    skid_addr_d   = skid_addr_q;
    skid_data_d   = skid_data_q;
    bus.rf_we     = 1'b0;
    bus.rf_waddr  = '0;
    bus.rf_wdata  = '0;

    // x0 writes are always accepted and silently dropped
    bus.ex_ready  = (bus.ex_waddr == '0) || ((state_q == SKID_EMPTY) && !ex_waw);
    ex_accept     = bus.ex_we && bus.ex_ready && (bus.ex_waddr != '0);

    unique case (state_q)
      SKID_EMPTY: begin
        if (ex_accept && lsu_we) begin
          state_d     = SKID_HELD;
          skid_addr_d = bus.ex_waddr;
          skid_data_d = bus.ex_wdata;
        end
      end
      SKID_HELD: begin
        if (!lsu_we) state_d = SKID_EMPTY;
      end
      default: state_d = SKID_EMPTY;
    endcase

    if (lsu_we) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = head_addr;
      bus.rf_wdata = bus.lsu_rdata;
    end else if (state_q == SKID_HELD) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = skid_addr_q;
      bus.rf_wdata = skid_data_q;
    end else if (ex_accept) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.ex_waddr;
      bus.rf_wdata = bus.ex_wdata;
    end

    // Nothing may reach the register file while reset is asserted
    if (!rst_ni) bus.rf_we = 1'b0;
  end

  // Decode hazard, forwarding and status outputs
  always_comb begin
    bus.lsu_req_ready = !full;
    bus.pending_cnt   = count_q;
`ifdef IBEX_RF_WB_FWD_EN
    bus.stall    = fifo_hit_a || fifo_hit_b;
    bus.fwd_a    = skid_hit_a;
    bus.fwd_b    = skid_hit_b;
    bus.fwd_data = skid_data_q;
`else
    bus.stall    = fifo_hit_a || fifo_hit_b || skid_hit_a || skid_hit_b;
    bus.fwd_a    = 1'b0;
    bus.fwd_b    = 1'b0;
    bus.fwd_data = '0;
`endif
  end

  // A load response must always have a reserved destination
  rvalid_needs_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.lsu_rvalid |-> !empty);

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed-vector bench for ibex_rf_wb_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 more
// unit later, before the next edge commits state.
module tb_ibex_rf_wb_arbiter;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  always #5 clk_i = ~clk_i;

  ibex_rf_wb_arbiter_if #(.MaxOutstanding(2), .DataWidth(32)) bus ();

  ibex_rf_wb_arbiter #(.MaxOutstanding(2), .DataWidth(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.ex_we = 1'b0; bus.ex_waddr = '0; bus.ex_wdata = '0;
    bus.lsu_req = 1'b0; bus.lsu_req_waddr = '0;
    bus.lsu_rvalid = 1'b0; bus.lsu_err = 1'b0; bus.lsu_rdata = '0;
    bus.raddr_a = '0; bus.raddr_b = '0; bus.ren_a = 1'b0; bus.ren_b = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    // Reset values
    #12;
    check("rst_rf_we",     32'(bus.rf_we),         32'd0);
    check("rst_stall",     32'(bus.stall),         32'd0);
    check("rst_fwd_a",     32'(bus.fwd_a),         32'd0);
    check("rst_pending",   32'(bus.pending_cnt),   32'd0);
    check("rst_ex_ready",  32'(bus.ex_ready),      32'd1);
    check("rst_req_ready", 32'(bus.lsu_req_ready), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Plain EX write goes straight to the port
    tick();
    bus.ex_we = 1'b1; bus.ex_waddr = 5'd5; bus.ex_wdata = 32'hA5A5_0001;
    settle();
    check("ex_we",    32'(bus.rf_we),    32'd1);
    check("ex_waddr", 32'(bus.rf_waddr), 32'd5);
    check("ex_wdata", bus.rf_wdata,      32'hA5A5_0001);

    // Load x7: read of x7 stalls through the response cycle
    tick(); idle();
    bus.lsu_req = 1'b1; bus.lsu_req_waddr = 5'd7;
    settle();
    check("ld7_req_ready", 32'(bus.lsu_req_ready), 32'd1);
    tick(); idle();
    bus.ren_a = 1'b1; bus.raddr_a = 5'd7;
    settle();
    check("ld7_stall",   32'(bus.stall),       32'd1);
    check("ld7_pending", 32'(bus.pending_cnt), 32'd1);
    tick();
    bus.lsu_rvalid = 1'b1; bus.lsu_rdata = 32'h0000_1234;
    settle();
    check("ld7_resp_stall", 32'(bus.stall),    32'd1);
    check("ld7_resp_we",    32'(bus.rf_we),    32'd1);
    check("ld7_resp_addr",  32'(bus.rf_waddr), 32'd7);
    check("ld7_resp_data",  bus.rf_wdata,      32'h0000_1234);
    tick();
    bus.lsu_rvalid = 1'b0; bus.lsu_rdata = '0;
    settle();
    check("ld7_after_stall",   32'(bus.stall),       32'd0);
    check("ld7_after_pending", 32'(bus.pending_cnt), 32'd0);

    // Collision: load response x7 and EX write x9 in the same cycle
    tick(); idle();
    bus.lsu_req = 1'b1; bus.lsu_req_waddr = 5'd7;
    tick(); idle();
    bus.lsu_rvalid = 1'b1; bus.lsu_rdata = 32'h0000_0055;
    bus.ex_we = 1'b1; bus.ex_waddr = 5'd9; bus.ex_wdata = 32'h0000_0099;
    settle();
    check("col_ex_ready", 32'(bus.ex_ready), 32'd1);
    check("col_addr",     32'(bus.rf_waddr), 32'd7);
    check("col_data",     bus.rf_wdata,      32'h0000_0055);
    tick(); idle();
    bus.ren_a = 1'b1; bus.raddr_a = 5'd9;
    bus.ex_we = 1'b1; bus.ex_waddr = 5'd3; bus.ex_wdata = 32'h0000_0033;
    settle();
    check("held_ex_ready", 32'(bus.ex_ready), 32'd0);
    check("held_we",       32'(bus.rf_we),    32'd1);
    check("held_addr",     32'(bus.rf_waddr), 32'd9);
    check("held_data",     bus.rf_wdata,      32'h0000_0099);
`ifdef IBEX_RF_WB_FWD_EN
    check("held_stall",    32'(bus.stall),    32'd0);
    check("held_fwd_a",    32'(bus.fwd_a),    32'd1);
    check("held_fwd_data", bus.fwd_data,      32'h0000_0099);
`else
    check("held_stall",    32'(bus.stall),    32'd1);
    check("held_fwd_a",    32'(bus.fwd_a),    32'd0);
    check("held_fwd_data", bus.fwd_data,      32'h0000_0000);
`endif
    tick();
    settle();
    check("drain_ex_ready", 32'(bus.ex_ready), 32'd1);
    check("drain_stall",    32'(bus.stall),    32'd0);
    check("drain_addr",     32'(bus.rf_waddr), 32'd3);
    check("drain_data",     bus.rf_wdata,      32'h0000_0033);

    // Fill the FIFO; a full FIFO refuses reservations even while popping
    tick(); idle();
    bus.lsu_req = 1'b1; bus.lsu_req_waddr = 5'd10;
    tick();
    bus.lsu_req_waddr = 5'd11;
    tick(); idle();
    settle();
    check("full_req_ready", 32'(bus.lsu_req_ready), 32'd0);
    check("full_pending",   32'(bus.pending_cnt),   32'd2);
    bus.lsu_req = 1'b1; bus.lsu_req_waddr = 5'd12;
    bus.lsu_rvalid = 1'b1; bus.lsu_err = 1'b1; bus.lsu_rdata = 32'hDEAD_BEEF;
    settle();
    check("err_req_ready", 32'(bus.lsu_req_ready), 32'd0);
    check("err_no_we",     32'(bus.rf_we),         32'd0);
    tick(); idle();
    settle();
    check("err_pending", 32'(bus.pending_cnt), 32'd1);

    // WAW: EX write to x11 waits for the pending load to x11
    bus.ex_we = 1'b1; bus.ex_waddr = 5'd11; bus.ex_wdata = 32'h0000_0E11;
    settle();
    check("waw_ready", 32'(bus.ex_ready), 32'd0);
    check("waw_no_we", 32'(bus.rf_we),    32'd0);
    tick();
    bus.lsu_rvalid = 1'b1; bus.lsu_rdata = 32'h0000_00BB;
    settle();
    check("waw_resp_ready", 32'(bus.ex_ready), 32'd0);
    check("waw_resp_addr",  32'(bus.rf_waddr), 32'd11);
    check("waw_resp_data",  bus.rf_wdata,      32'h0000_00BB);
    tick();
    bus.lsu_rvalid = 1'b0; bus.lsu_rdata = '0;
    settle();
    check("waw_after_ready", 32'(bus.ex_ready), 32'd1);
    check("waw_after_data",  bus.rf_wdata,      32'h0000_0E11);

    // Load to x0: no stall, no write, entry still consumed
    tick(); idle();
    bus.lsu_req = 1'b1; bus.lsu_req_waddr = 5'd0;
    tick(); idle();
    bus.ren_a = 1'b1; bus.raddr_a = 5'd0;
    settle();
    check("x0_stall",   32'(bus.stall),       32'd0);
    check("x0_pending", 32'(bus.pending_cnt), 32'd1);
    tick();
    bus.lsu_rvalid = 1'b1; bus.lsu_rdata = 32'h0000_00FF;
    settle();
    check("x0_no_we", 32'(bus.rf_we), 32'd0);
    tick(); idle();
    settle();
    check("x0_pending_after", 32'(bus.pending_cnt), 32'd0);

    // Reset mid-operation drops state and suppresses writes
    bus.lsu_req = 1'b1; bus.lsu_req_waddr = 5'd12;
    tick(); idle();
    bus.ex_we = 1'b1; bus.ex_waddr = 5'd4; bus.ex_wdata = 32'h0000_0044;
    rst_ni = 1'b0;
    settle();
    check("mrst_no_we",   32'(bus.rf_we),       32'd0);
    check("mrst_pending", 32'(bus.pending_cnt), 32'd0);
    idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    bus.ren_a = 1'b1; bus.raddr_a = 5'd12;
    settle();
    check("mrst_stall", 32'(bus.stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
